// File: rtl/regwriter_pkg.sv
// Shared types for the register-file write-back sequencer.
// Optional trace output is enabled with the REGWRITER_TRACE_EN macro.
package regwriter_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 1 << REG_W;

    typedef struct packed {
        logic              live;
        logic [REG_W-1:0]  wreg;
        logic [DATA_W-1:0] wdata;
    } q_entry_t;

    typedef enum logic {
        SRC_ALU,
        SRC_LD
    } src_e;

    function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
        return NREGS'(1) << r;
    endfunction

endpackage

// File: rtl/regwriter_queue.sv
// In-order load result queue with per-entry squash and pending-register bitmap.
// REGWRITER_TRACE_EN adds a simulation display of each squashed entry.
module regwriter_queue
    import regwriter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  q_entry_t               i_push_entry,
    input  logic                   i_pop,
    input  logic                   i_sq_en,
    input  logic [REG_W-1:0]       i_sq_wreg,
    output q_entry_t               o_head,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [NREGS-1:0]       o_pend
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    q_entry_t          r_mem [DEPTH];
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    logic              w_push;
    logic              w_pop;
    logic [NREGS-1:0]  w_pend;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_head];
    assign o_count = r_count;

    // Free slots always carry live=0, so the bitmap can scan every slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_sq_en && r_mem[i].live && r_mem[i].wreg == i_sq_wreg) begin
                    r_mem[i].live <= 1'b0;
                end
            end
            if (w_pop) begin
                r_mem[r_head].live <= 1'b0;
                r_head             <= r_head + AW'(1);
            end
            // The tail slot is free here, so a same-cycle squash never hits it.
            if (w_push) begin
                r_mem[r_tail] <= i_push_entry;
                r_tail        <= r_tail + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_mem[i].live) begin
                w_pend = w_pend | reg_onehot(r_mem[i].wreg);
            end
        end
        w_pend[0] = 1'b0;
    end

    assign o_pend = w_pend;

`ifdef REGWRITER_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_sq_en && r_mem[i].live && r_mem[i].wreg == i_sq_wreg) begin
                    $display("%0t regwriter squash slot%0d x%0d=%h",
                             $time, i, r_mem[i].wreg, r_mem[i].wdata);
                end
            end
        end
    end
`endif

endmodule

// File: rtl/regwriter.sv
// Write-back sequencer: ALU results win the port, loads drain in order.
// REGWRITER_TRACE_EN adds a simulation display of every register write.
module regwriter
    import regwriter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_we,
    input  logic [REG_W-1:0]       alu_wreg,
    input  logic [DATA_W-1:0]      alu_wdata,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [REG_W-1:0]       ld_wreg,
    input  logic [DATA_W-1:0]      ld_wdata,
    output logic                   we,
    output logic [REG_W-1:0]       wreg,
    output logic [DATA_W-1:0]      wdata,
    output logic [NREGS-1:0]       pend,
    output logic [$clog2(DEPTH):0] count
);

    q_entry_t          w_head;
    q_entry_t          w_push_entry;
    logic              w_empty;
    logic              w_full;
    logic              w_alu_issue;
    logic              w_ld_issue;
    logic              w_pop;

    logic              r_we;
    logic [REG_W-1:0]  r_wreg;
    logic [DATA_W-1:0] r_wdata;

    assign w_alu_issue = alu_we && (alu_wreg != '0);
    assign w_ld_issue  = !w_empty && w_head.live && !w_alu_issue;
    // Dead heads drain every cycle; live heads leave only when written.
    assign w_pop       = !w_empty && (!w_head.live || w_ld_issue);

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.live  = (ld_wreg != '0);
        w_push_entry.wreg  = ld_wreg;
        w_push_entry.wdata = ld_wdata;
    end

    regwriter_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .i_push      (ld_valid),
        .i_push_entry(w_push_entry),
        .i_pop       (w_pop),
        .i_sq_en     (w_alu_issue),
        .i_sq_wreg   (alu_wreg),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_count     (count),
        .o_pend      (pend)
    );

    assign ld_ready = !w_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else if (w_alu_issue) begin
            r_we    <= 1'b1;
            r_wreg  <= alu_wreg;
            r_wdata <= alu_wdata;
        end else if (w_ld_issue) begin
            r_we    <= 1'b1;
            r_wreg  <= w_head.wreg;
            r_wdata <= w_head.wdata;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign we    = r_we;
    assign wreg  = r_wreg;
    assign wdata = r_wdata;

`ifdef REGWRITER_TRACE_EN
    src_e r_src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src <= SRC_ALU;
        end else if (w_alu_issue) begin
            r_src <= SRC_ALU;
        end else if (w_ld_issue) begin
            r_src <= SRC_LD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && r_we) begin
            $display("%0t regwriter write x%0d=%h src=%s",
                     $time, r_wreg, r_wdata, (r_src == SRC_ALU) ? "ALU" : "LD");
        end
    end
`endif

endmodule

// File: tb/tb_regwriter.sv
// Directed vector bench for regwriter: per-cycle table plus full/wrap and reset sequences.
module tb_regwriter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_we;
    logic [4:0]  alu_wreg;
    logic [31:0] alu_wdata;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_wreg;
    logic [31:0] ld_wdata;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [31:0] pend;
    logic [2:0]  count;

    int nvec = 0;
    int nerr = 0;

    regwriter #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .alu_we   (alu_we),
        .alu_wreg (alu_wreg),
        .alu_wdata(alu_wdata),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_wreg  (ld_wreg),
        .ld_wdata (ld_wdata),
        .we       (we),
        .wreg     (wreg),
        .wdata    (wdata),
        .pend     (pend),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        aw;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lr;
        logic [31:0] ld;
        logic        ewe;
        logic [4:0]  ereg;
        logic [31:0] edata;
        int          ecnt;
        logic [31:0] epend;
    } vec_t;

    vec_t tv[28];

    function automatic vec_t v(input logic aw, input logic [4:0] ar, input logic [31:0] ad,
                               input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                               input logic ewe, input logic [4:0] ereg, input logic [31:0] edata,
                               input int ecnt, input logic [31:0] epend);
        vec_t t;
        t.aw = aw; t.ar = ar; t.ad = ad;
        t.lv = lv; t.lr = lr; t.ld = ld;
        t.ewe = ewe; t.ereg = ereg; t.edata = edata;
        t.ecnt = ecnt; t.epend = epend;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic aw, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        alu_we = aw; alu_wreg = ar; alu_wdata = ad;
        ld_valid = lv; ld_wreg = lr; ld_wdata = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drv(0, 0, 0, 0, 0, 0);
        // basic ALU, single load, empty idle
        tv[0]  = v(1, 10, 32'h1234, 0, 0, 0,       1, 10, 32'h1234, 0, 32'h0);
        tv[1]  = v(0, 0, 0,         0, 0, 0,       0, 0, 0,         0, 32'h0);
        tv[2]  = v(0, 0, 0,         1, 8, 32'hCAFE, 0, 0, 0,        1, 32'h100);
        tv[3]  = v(0, 0, 0,         0, 0, 0,       1, 8, 32'hCAFE,  0, 32'h0);
        tv[4]  = v(0, 0, 0,         0, 0, 0,       0, 0, 0,         0, 32'h0);
        // ALU contention with loads to 12, 13
        tv[5]  = v(1, 1, 32'h11,    1, 12, 32'hC12, 1, 1, 32'h11,   1, 32'h1000);
        tv[6]  = v(1, 2, 32'h22,    1, 13, 32'hC13, 1, 2, 32'h22,   2, 32'h3000);
        tv[7]  = v(1, 3, 32'h33,    0, 0, 0,       1, 3, 32'h33,    2, 32'h3000);
        tv[8]  = v(0, 0, 0,         0, 0, 0,       1, 12, 32'hC12,  1, 32'h2000);
        tv[9]  = v(0, 0, 0,         0, 0, 0,       1, 13, 32'hC13,  0, 32'h0);
        tv[10] = v(0, 0, 0,         0, 0, 0,       0, 0, 0,         0, 32'h0);
        // squash of reg 15
        tv[11] = v(0, 0, 0,         1, 15, 32'hF15, 0, 0, 0,        1, 32'h8000);
        tv[12] = v(1, 15, 32'h1,    0, 0, 0,       1, 15, 32'h1,    1, 32'h0);
        tv[13] = v(0, 0, 0,         0, 0, 0,       0, 0, 0,         0, 32'h0);
        tv[14] = v(0, 0, 0,         0, 0, 0,       0, 0, 0,         0, 32'h0);
        // register 0 from both sources
        tv[15] = v(1, 0, 32'h99,    1, 0, 32'h77,  0, 0, 0,         1, 32'h0);
        tv[16] = v(0, 0, 0,         0, 0, 0,       0, 0, 0,         0, 32'h0);
        // same-cycle enqueue and squash of reg 20
        tv[17] = v(0, 0, 0,         1, 20, 32'hA,  0, 0, 0,         1, 32'h100000);
        tv[18] = v(1, 20, 32'hB,    1, 20, 32'hC,  1, 20, 32'hB,    2, 32'h100000);
        tv[19] = v(0, 0, 0,         0, 0, 0,       0, 0, 0,         1, 32'h100000);
        tv[20] = v(0, 0, 0,         0, 0, 0,       1, 20, 32'hC,    0, 32'h0);
        // ALU write to x0 does not block the load
        tv[21] = v(0, 0, 0,         1, 5, 32'h55,  0, 0, 0,         1, 32'h20);
        tv[22] = v(1, 0, 32'hEE,    0, 0, 0,       1, 5, 32'h55,    0, 32'h0);
        tv[23] = v(0, 0, 0,         0, 0, 0,       0, 0, 0,         0, 32'h0);
        // enqueue and pop in the same cycle
        tv[24] = v(0, 0, 0,         1, 6, 32'h66,  0, 0, 0,         1, 32'h40);
        tv[25] = v(0, 0, 0,         1, 7, 32'h77,  1, 6, 32'h66,    1, 32'h80);
        tv[26] = v(0, 0, 0,         0, 0, 0,       1, 7, 32'h77,    0, 32'h0);
        tv[27] = v(0, 0, 0,         0, 0, 0,       0, 0, 0,         0, 32'h0);

        tick();
        tick();
        chk("rst_we", 32'(we), 32'h0);
        chk("rst_wreg", 32'(wreg), 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_pend", pend, 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_ready", 32'(ld_ready), 32'h1);
        rst = 1'b0;

        for (int i = 0; i < 28; i++) begin
            drv(tv[i].aw, tv[i].ar, tv[i].ad, tv[i].lv, tv[i].lr, tv[i].ld);
            tick();
            chk($sformatf("v%0d_we", i), 32'(we), 32'(tv[i].ewe));
            if (tv[i].ewe) begin
                chk($sformatf("v%0d_wreg", i), 32'(wreg), 32'(tv[i].ereg));
                chk($sformatf("v%0d_wdata", i), wdata, tv[i].edata);
            end
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tv[i].ecnt));
            chk($sformatf("v%0d_ready", i), 32'(ld_ready), 32'(tv[i].ecnt != DEPTH));
            chk($sformatf("v%0d_pend", i), pend, tv[i].epend);
        end

        // fill with the ALU busy, then drain in order; pointers wrap each round
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < 4; k++) begin
                drv(1, 31, 32'hA000 + k, 1, 5'(16 + k), 32'(rep * 256 + k));
                tick();
                chk($sformatf("f%0d_%0d_alu", rep, k), {we, 27'(0), wreg}, {1'b1, 27'(0), 5'd31});
                chk($sformatf("f%0d_%0d_count", rep, k), 32'(count), 32'(k + 1));
            end
            chk($sformatf("f%0d_ready", rep), 32'(ld_ready), 32'h0);
            chk($sformatf("f%0d_pend", rep), pend, 32'h000F_0000);
            drv(1, 31, 32'hA004, 1, 30, 32'hDEAD);
            tick();
            chk($sformatf("f%0d_nopush", rep), 32'(count), 32'h4);
            drv(0, 0, 0, 1, 30, 32'hDEAD);
            tick();
            chk($sformatf("f%0d_d0_reg", rep), {we, 27'(0), wreg}, {1'b1, 27'(0), 5'd16});
            chk($sformatf("f%0d_d0_data", rep), wdata, 32'(rep * 256));
            chk($sformatf("f%0d_d0_count", rep), 32'(count), 32'h3);
            drv(0, 0, 0, 0, 0, 0);
            for (int k = 1; k < 4; k++) begin
                tick();
                chk($sformatf("f%0d_d%0d_reg", rep, k), {we, 27'(0), wreg}, {1'b1, 27'(0), 5'(16 + k)});
                chk($sformatf("f%0d_d%0d_data", rep, k), wdata, 32'(rep * 256 + k));
                chk($sformatf("f%0d_d%0d_count", rep, k), 32'(count), 32'(3 - k));
            end
            tick();
            chk($sformatf("f%0d_idle_we", rep), 32'(we), 32'h0);
        end

        // reset mid-stream with three queued loads
        drv(1, 31, 32'h1, 1, 9, 32'h9);
        tick();
        drv(1, 31, 32'h2, 1, 10, 32'h10);
        tick();
        drv(1, 31, 32'h3, 1, 11, 32'h11);
        tick();
        chk("mr_count", 32'(count), 32'h3);
        chk("mr_pend", pend, 32'h0000_0E00);
        #2 rst = 1'b1;
        #1;
        chk("mr_we", 32'(we), 32'h0);
        chk("mr_wreg", 32'(wreg), 32'h0);
        chk("mr_wdata", wdata, 32'h0);
        chk("mr_count0", 32'(count), 32'h0);
        chk("mr_pend0", pend, 32'h0);
        chk("mr_ready", 32'(ld_ready), 32'h1);
        tick();
        tick();
        chk("mr_held_we", 32'(we), 32'h0);
        chk("mr_held_count", 32'(count), 32'h0);
        #2 rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("mr_post%0d_we", k), 32'(we), 32'h0);
        end
        chk("mr_post_ready", 32'(ld_ready), 32'h1);
        chk("mr_post_count", 32'(count), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/regwriter.md
# regwriter

Write-back sequencer driving the single write port (`we`/`wreg`/`wdata`) of the 32×32 register file. It merges two result sources into at most one register write per cycle:
- the ALU path, which is always accepted;
- the load path, which is buffered in a small in-order queue with a valid/ready handshake.

It also exports a pending-write bitmap so decode can stall on registers with an outstanding load.

## Interface
Parameters:
- `DEPTH`, 4, load-queue entries; power of two, ≥2.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `alu_we` in 1: ALU result valid this cycle; never back-pressured.
- `alu_wreg` in 5: ALU destination register.
- `alu_wdata` in 32: ALU result.
- `ld_valid` in 1: load result offered.
- `ld_ready` out 1: queue can accept; equals `!full`.
- `ld_wreg` in 5: load destination register.
- `ld_wdata` in 32: load data.
- `we` out 1: register-file write enable (registered).
- `wreg` out 5: register-file write address (registered).
- `wdata` out 32: register-file write data (registered).
- `pend` out 32: bit r set iff a live queued load targets register r; bit 0 always 0.
- `count` out $clog2(DEPTH)+1: occupied queue entries, including squashed entries.

## Operation
- Load enqueue: on a clock edge with `ld_valid && ld_ready`.
  - Entry = {live=1, wreg, wdata}.
  - An entry with `ld_wreg==0` is enqueued with live=0.
- Issue priority each cycle:
  - `alu_we && alu_wreg!=0` wins the write port.
  - Otherwise the head entry is issued if it is live.
- Head pop:
  - A squashed (live=0) head is popped every cycle regardless of ALU activity, with no write generated.
  - A live head pops only when it is issued.
- Squash: an ALU write (`alu_we`, `alu_wreg!=0`) kills every live queued entry with the same wreg in that cycle. ALU results are defined as program-order younger than any queued load.
- Writes to register 0 from either source never assert `we`.
- `pend` is the OR over live entries of their one-hot wreg. It updates on the same edge as enqueue, pop, or squash.
- Full/empty behaviour:
  - `ld_ready` is 0 when `count==DEPTH`, even if a pop occurs that cycle; no same-cycle enqueue into a full queue.
  - An empty queue with no ALU write gives `we`=0 on the next edge.
- Simultaneous enqueue and pop on a non-full queue: both happen; `count` unchanged.
- Simultaneous enqueue and squash of the same wreg in one cycle: the newly enqueued entry is NOT squashed; only entries already resident are.
- Inputs are ignored while `rst` is high.

## Timing
- Reset values (asynchronous): queue empty, `count`=0, `we`=0, `wreg`=0, `wdata`=0, `pend`=0, `ld_ready`=1.
- ALU latency: inputs sampled at edge N; `we`/`wreg`/`wdata` valid after edge N; register file written at edge N+1.
- Load latency (empty queue, no ALU contention):
  - enqueue at edge N;
  - issue at edge N+1;
  - register file written at edge N+2.
- Each cycle of ALU contention adds one cycle of load latency.
- `we` is high for exactly one cycle per issued write.
- A reset asserted mid-operation discards all queued entries immediately; no write is produced for them.

## Configuration
- `REGWRITER_TRACE_EN` defined:
  - simulation-only `$display` of time, wreg, wdata and source (ALU/LD) on every cycle `we` is asserted;
  - `$display` of every squashed entry.
- Undefined: no display statements are compiled; RTL behaviour is identical either way.

## Structure
- Shared package `regwriter_pkg` holds:
  - `REG_W`=5 and `DATA_W`=32;
  - the queue entry typedef {live, wreg, wdata};
  - the source enum {SRC_ALU, SRC_LD}.
- Sub-module `regwriter_queue`: circular buffer of `DEPTH` entries with head/tail pointers and wrap-around. It provides:
  - push/pop;
  - a per-entry squash compare port (`sq_en`, `sq_wreg`);
  - a combinational `pend` OR-reduction.
- The top level holds issue arbitration and the output registers.

## Test plan
- ALU only: `alu_we`=1, wreg=10, data=0x1234 at edge N → `we`=1, `wreg`=10, `wdata`=0x1234 after edge N, `we`=0 next cycle.
- Load through empty queue: wreg=8, data=0xCAFE → `pend[8]`=1 after enqueue; write appears one edge later; `pend[8]`=0 after issue.
- Contention: ALU writes on 3 consecutive cycles while 2 loads (regs 12, 13) are queued → ALU writes issue first, then 12, then 13, in order.
- Full/wrap: with `DEPTH`=4 and ALU busy, push 4 loads → `ld_ready`=0, `count`=4; release the ALU → 4 in-order writes, with pointers wrapping; repeat twice more.
- Squash: queue load to reg 15, then ALU writes reg 15 = 0x1 → `pend[15]` clears; no later write to 15 from the load; `count` drops by 1 without `we`.
- Reset mid-stream: assert `rst` with 3 entries queued → outputs zero immediately; no writes after release; `ld_ready`=1.
